t08_debug_display: RTL and testbench

Parametrised FPGA debug display block that captures several multi-digit hex data channels (I2C data_out, program counter, CPU state, ...) and drives one bank of seven-segment digits. Replaces the hard-wired clock divider plus fixed ssdec array in the team_08 FPGA top. Adds per-channel capture and freeze, a debounced pushbutton channel selector, timed auto-rotation, and freshness flags. Sits in the FPGA top between design debug signals and the ss*/left/right board outputs; output polarity is adapted in the top.

---
 rtl/t08_debug_pkg.sv | 47 ++++
 rtl/t08_debounce.sv | 76 +++++++
 rtl/t08_debug_display.sv | 145 ++++++++++++++
 tb/tb_t08_debug_display.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/t08_debug_pkg.sv
`default_nettype none
// ============================================================================
// Module : t08_debug_pkg
// Purpose: Shared constants and the hex-to-seven-segment decoder used by the
//          debug display block.
//          Segment byte layout is {dp,g,f,e,d,c,b,a}, active high.
// Rev    : 1.0  initial release
// ============================================================================
package t08_debug_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Standard gfedcba glyphs; dp is always returned clear.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0:    s = 8'h3F;
      4'h1:    s = 8'h06;
      4'h2:    s = 8'h5B;
      4'h3:    s = 8'h4F;
      4'h4:    s = 8'h66;
      4'h5:    s = 8'h6D;
      4'h6:    s = 8'h7D;
      4'h7:    s = 8'h07;
      4'h8:    s = 8'h7F;
      4'h9:    s = 8'h6F;
      4'hA:    s = 8'h77;
      4'hB:    s = 8'h7C;
      4'hC:    s = 8'h39;
      4'hD:    s = 8'h5E;
      4'hE:    s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/t08_debounce.sv
`default_nettype none
// ============================================================================
// Module : t08_debounce
// Purpose: Pushbutton conditioner: 2-flop synchroniser, tick-qualified
//          stability counter and rising-edge pulse of the debounced level.
// Ports  : hwclk   in  system clock
//          reset   in  asynchronous, active-high reset
//          tick    in  qualifying strobe for the stability counter
//          btn_raw in  raw asynchronous button
//          rise    out one-cycle pulse on debounced 0->1 (armed only)
// Rev    : 1.0  initial release
// ============================================================================
module t08_debounce #(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic hwclk,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  output logic rise
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] stab_q,  stab_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    armed_d = armed_q;
    stab_d  = stab_q;
    rise    = 1'b0;
    if (tick) begin
      // A button held through reset must not produce a press: rising edges
      // are only reported once the button has been seen released.
      if (!sync2_q) begin
        armed_d = 1'b1;
      end
      if (sync2_q != level_q) begin
        if (stab_q == CNT_LAST) begin
          level_d = sync2_q;
          stab_d  = '0;
          rise    = sync2_q & armed_q;
        end else begin
          stab_d = stab_q + CNT_W'(1);
        end
      end else begin
        stab_d = '0;
      end
    end
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      stab_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      armed_q <= armed_d;
      stab_q  <= stab_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/t08_debug_display.sv
`default_nettype none
// ============================================================================
// Module : t08_debug_display
// Purpose: Multi-channel hex debug display: per-channel capture with freeze,
//          debounced channel-advance button, timed auto-rotation, freshness
//          flags and a registered seven-segment output bank.
// Ports  : hwclk, reset (async, active high)
//          ch_data   in  packed channel data, channel i at [i*DIGITS*4 +: DIGITS*4]
//          ch_valid  in  per-channel capture strobe
//          freeze    in  blocks all captures; lit on digit 0 dp
//          btn_next  in  raw pushbutton, advances sel
//          auto_mode in  enables timed rotation
//          seg       out {dp,g,f,e,d,c,b,a} per digit, digit 0 at [7:0]
//          sel       out displayed channel
//          fresh     out captured since last selected
//          tick      out one-cycle tick pulse
// Rev    : 1.0  initial release
// ============================================================================
module t08_debug_display
  import t08_debug_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int DIGITS         = 8,
  parameter int DIV            = 12000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int ROTATE_TICKS   = 1000
) (
  input  logic                         hwclk,
  input  logic                         reset,
  input  logic [CHANNELS*DIGITS*4-1:0] ch_data,
  input  logic [CHANNELS-1:0]          ch_valid,
  input  logic                         freeze,
  input  logic                         btn_next,
  input  logic                         auto_mode,
  output logic [DIGITS*8-1:0]          seg,
  output logic [$clog2(CHANNELS)-1:0]  sel,
  output logic [CHANNELS-1:0]          fresh,
  output logic                         tick
);

  localparam int                DW       = DIGITS * 4;
  localparam int                SEL_W    = $clog2(CHANNELS);
  localparam int                DIV_W    = $clog2(DIV);
  localparam int                ROT_W    = $clog2(ROTATE_TICKS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [ROT_W-1:0]  ROT_LAST = ROT_W'(ROTATE_TICKS - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(CHANNELS - 1);

  logic [DIV_W-1:0]    div_q,    div_d;
  logic [ROT_W-1:0]    rot_q,    rot_d;
  logic [SEL_W-1:0]    sel_q,    sel_d;
  logic [CHANNELS-1:0] fresh_q,  fresh_d;
  logic [CHANNELS-1:0] loaded_q, loaded_d;
  logic [DW-1:0]       data_q [CHANNELS];
  logic [DW-1:0]       data_d [CHANNELS];
  logic [DIGITS*8-1:0] seg_q,    seg_d;

  logic             manual_adv;
  logic             auto_adv;
  logic             adv;
  logic [SEL_W-1:0] sel_nxt;
  logic [DW-1:0]    cur_data;

  t08_debounce #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_btn_next (
    .hwclk   (hwclk),
    .reset   (reset),
    .tick    (tick),
    .btn_raw (btn_next),
    .rise    (manual_adv)
  );

  assign tick     = (div_q == DIV_LAST);
  assign auto_adv = auto_mode & tick & (rot_q == ROT_LAST);
  assign adv      = manual_adv | auto_adv;
  assign sel_nxt  = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
  assign cur_data = data_q[sel_q];

  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);

    // Rotation is idle-at-zero whenever disabled, and a manual press
    // restarts the interval so the new channel gets a full dwell time.
    rot_d = rot_q;
    if (!auto_mode || manual_adv || auto_adv) begin
      rot_d = '0;
    end else if (tick) begin
      rot_d = rot_q + ROT_W'(1);
    end

    sel_d   = adv ? sel_nxt : sel_q;
    fresh_d = fresh_q;
    if (adv) begin
      fresh_d[sel_nxt] = 1'b0;
    end

    // Captures are applied after the selection clear so a capture into the
    // newly selected channel keeps it flagged fresh.
    loaded_d = loaded_q;
    for (int i = 0; i < CHANNELS; i++) begin
      data_d[i] = data_q[i];
      if (ch_valid[i] && !freeze) begin
        data_d[i]   = ch_data[i*DW +: DW];
        loaded_d[i] = 1'b1;
        fresh_d[i]  = 1'b1;
      end
    end

    for (int d = 0; d < DIGITS; d++) begin
      seg_d[d*8 +: 8] = loaded_q[sel_q] ? hex_to_seg(cur_data[d*4 +: 4]) : SEG_BLANK;
    end
    seg_d[SEG_DP] = freeze;
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      rot_q    <= '0;
      sel_q    <= '0;
      fresh_q  <= '0;
      loaded_q <= '0;
      seg_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      div_q    <= div_d;
      rot_q    <= rot_d;
      sel_q    <= sel_d;
      fresh_q  <= fresh_d;
      loaded_q <= loaded_d;
      seg_q    <= seg_d;
      for (int i = 0; i < CHANNELS; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign seg   = seg_q;
  assign sel   = sel_q;
  assign fresh = fresh_q;

endmodule
`default_nettype wire

// File: tb/tb_t08_debug_display.sv
`default_nettype none
// ============================================================================
// Module : tb_t08_debug_display
// Purpose: Directed self-checking bench for t08_debug_display
//          (CHANNELS=4, DIGITS=8, DIV=4, DEBOUNCE_TICKS=3, ROTATE_TICKS=5).
// Rev    : 1.0  initial release
// ============================================================================
module tb_t08_debug_display;

  logic         hwclk;
  logic         reset;
  logic [127:0] ch_data;
  logic [3:0]   ch_valid;
  logic         freeze;
  logic         btn_next;
  logic         auto_mode;
  logic [63:0]  seg;
  logic [1:0]   sel;
  logic [3:0]   fresh;
  logic         tick;

  int checks;
  int errors;

  t08_debug_display #(
    .CHANNELS       (4),
    .DIGITS         (8),
    .DIV            (4),
    .DEBOUNCE_TICKS (3),
    .ROTATE_TICKS   (5)
  ) dut (
    .hwclk     (hwclk),
    .reset     (reset),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .freeze    (freeze),
    .btn_next  (btn_next),
    .auto_mode (auto_mode),
    .seg       (seg),
    .sel       (sel),
    .fresh     (fresh),
    .tick      (tick)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge hwclk);
  endtask

  // Leaves the bench at the negedge where tick is high (before the edge
  // that consumes it), n ticks later.
  task automatic wait_tick(input int n);
    for (int k = 0; k < n; k++) begin
      int b;
      b = 0;
      @(negedge hwclk);
      while (!tick && b < 20) begin
        @(negedge hwclk);
        b++;
      end
      if (!tick) check("tick_timeout", 64'd0, 64'd1);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    ch_data   = '0;
    ch_valid  = '0;
    freeze    = 1'b0;
    btn_next  = 1'b0;
    auto_mode = 1'b0;
    cyc();
    cyc();
    check("rst_seg",   seg,   64'h0);
    check("rst_sel",   sel,   2'd0);
    check("rst_fresh", fresh, 4'h0);
    check("rst_tick",  tick,  1'b0);
    reset = 1'b0;

    // Tick in cycles 4, 8, 12, ... after release
    for (int i = 1; i <= 20; i++) begin
      check($sformatf("tick_c%0d", i), tick, (i % 4 == 0) ? 1'b1 : 1'b0);
      cyc();
    end
    check("idle_seg",   seg,   64'h0);
    check("idle_sel",   sel,   2'd0);
    check("idle_fresh", fresh, 4'h0);

    // Capture channel 0
    ch_data[31:0] = 32'h0123_4567;
    ch_valid      = 4'b0001;
    cyc();
    ch_valid = 4'b0000;
    check("cap_fresh", fresh, 4'b0001);
    cyc();
    check("cap_seg", seg, 64'h3F065B4F666D7D07);

    // Freeze blocks capture; dp of digit 0 lit
    freeze = 1'b1;
    cyc();
    ch_data[31:0] = 32'hFFFF_FFFF;
    ch_valid      = 4'b0001;
    cyc();
    ch_valid = 4'b0000;
    cyc();
    check("frz_seg",   seg,   64'h3F065B4F666D7D87);
    check("frz_fresh", fresh, 4'b0001);
    freeze = 1'b0;
    cyc();
    cyc();
    check("unfrz_seg", seg, 64'h3F065B4F666D7D07);

    // Button high for only 2 ticks: rejected
    wait_tick(1);
    cyc();
    btn_next = 1'b1;
    wait_tick(2);
    cyc();
    btn_next = 1'b0;
    wait_tick(4);
    check("short_sel", sel, 2'd0);

    // Button held 3 ticks: one advance to unloaded channel 1
    cyc();
    btn_next = 1'b1;
    wait_tick(3);
    check("press_pre_sel", sel, 2'd0);
    cyc();
    check("press_sel",   sel,   2'd1);
    check("press_fresh", fresh, 4'b0001);
    cyc();
    check("press_seg_blank", seg, 64'h0);
    wait_tick(4);
    check("held_sel", sel, 2'd1);
    btn_next = 1'b0;
    wait_tick(4);

    // Simultaneous capture of channels 2 and 3
    cyc();
    ch_data[95:64]  = 32'h89AB_CDEF;
    ch_data[127:96] = 32'hDEAD_BEEF;
    ch_valid        = 4'b1100;
    cyc();
    ch_valid = 4'b0000;
    check("multi_fresh", fresh, 4'b1101);

    // Auto rotation every 5 ticks
    auto_mode = 1'b1;
    wait_tick(5);
    check("auto_pre_sel", sel, 2'd1);
    cyc();
    check("auto1_sel",   sel,   2'd2);
    check("auto1_fresh", fresh, 4'b1001);
    cyc();
    check("auto1_seg", seg, 64'h7F6F777C395E7971);
    wait_tick(5);
    cyc();
    check("auto2_sel",   sel,   2'd3);
    check("auto2_fresh", fresh, 4'b0001);

    // Wrap 3->0 with a capture on channel 0 in the same cycle: set wins
    wait_tick(5);
    ch_data[31:0] = 32'h0000_0000;
    ch_valid      = 4'b0001;
    cyc();
    ch_valid = 4'b0000;
    check("wrap_sel",   sel,   2'd0);
    check("wrap_fresh", fresh, 4'b0001);
    cyc();
    check("wrap_seg", seg, 64'h3F3F3F3F3F3F3F3F);

    // Debounced press landing on the auto-advance tick
    wait_tick(2);
    cyc();
    btn_next = 1'b1;
    wait_tick(3);
    check("coin_pre_sel", sel, 2'd0);
    cyc();
    check("coin_sel", sel, 2'd1);
    wait_tick(4);
    cyc();
    check("coin_hold_sel", sel, 2'd1);
    wait_tick(1);
    cyc();
    check("coin_next_sel", sel, 2'd2);

    // Reset mid-debounce with the button held
    auto_mode = 1'b0;
    btn_next  = 1'b0;
    wait_tick(4);
    cyc();
    btn_next = 1'b1;
    wait_tick(2);
    cyc();
    reset = 1'b1;
    #1;
    check("arst_seg",   seg,   64'h0);
    check("arst_sel",   sel,   2'd0);
    check("arst_fresh", fresh, 4'h0);
    check("arst_tick",  tick,  1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    wait_tick(6);
    check("post_rst_held_sel", sel, 2'd0);
    check("post_rst_seg",      seg, 64'h0);
    btn_next = 1'b0;
    wait_tick(4);
    cyc();
    btn_next = 1'b1;
    wait_tick(4);
    cyc();
    check("repress_sel", sel, 2'd1);
    btn_next = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
